// File: rtl/dma_sequencer_pkg.sv
// Shared FSM states and DMA register map for the fCore
// input/output sequencers.
package dma_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND_CURRENT,
    SEND_SPEED,
    START
  } seq_state_t;

  localparam int CURRENT_DMA_ADDRESS = 1;
  localparam int SPEED_DMA_ADDRESS   = 2;
  localparam int DUTY_DMA_ADDRESS    = 15;

endpackage

// File: rtl/dma_input_sequencer_if.sv
// AXI-stream-style write channel into the fCore DMA
// register file.
interface dma_input_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic [DEST_WIDTH-1:0] tdest;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tdest,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tdest,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/dma_sample_latch.sv
// One-deep sample holding register with pending flag and
// overrun detection.
module dma_sample_latch #(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] data,
  input  logic                    consume,
  output logic [SAMPLE_WIDTH-1:0] held,
  output logic                    pending,
  output logic                    overrun
);

  // a strobe in the consume cycle is a fresh sample, not a loss
  assign overrun = valid && pending && !consume;

  always_ff @(posedge clock) begin
    if (!reset) begin
      held    <= '0;
      pending <= 1'b0;
    end else begin
      if (valid) begin
        held <= data;
      end
      if (valid) begin
        pending <= 1'b1;
      end else if (consume) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dma_input_sequencer.sv
// Pairs current/speed samples, writes them to the fCore DMA
// registers and pulses core_start once per delivered pair.
module dma_input_sequencer
  import dma_sequencer_pkg::*;
#(
  parameter int SAMPLE_WIDTH    = 16,
  parameter int DMA_DATA_WIDTH  = 32,
  parameter int DEST_WIDTH      = 8,
  parameter int CURRENT_ADDRESS = CURRENT_DMA_ADDRESS,
  parameter int SPEED_ADDRESS   = SPEED_DMA_ADDRESS,
  parameter int OVERRUN_WIDTH   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     current_valid,
  input  logic [SAMPLE_WIDTH-1:0]  current_data,
  input  logic                     speed_valid,
  input  logic [SAMPLE_WIDTH-1:0]  speed_data,
  dma_input_sequencer_if.master    dma,
  output logic                     core_start,
  output logic                     busy,
  output logic [OVERRUN_WIDTH-1:0] overrun_count,
  input  logic                     clear_overrun
);

  if (SAMPLE_WIDTH > DMA_DATA_WIDTH) begin : g_bad_width
    $error("SAMPLE_WIDTH exceeds DMA_DATA_WIDTH");
  end

  if (CURRENT_ADDRESS < 0 ||
      CURRENT_ADDRESS > (2**DEST_WIDTH) - 1 ||
      SPEED_ADDRESS < 0 ||
      SPEED_ADDRESS > (2**DEST_WIDTH) - 1) begin : g_bad_addr
    $error("DMA address does not fit in DEST_WIDTH");
  end

  seq_state_t state;
  seq_state_t state_n;

  logic [SAMPLE_WIDTH-1:0] cur_held;
  logic [SAMPLE_WIDTH-1:0] spd_held;
  logic                    cur_pend;
  logic                    spd_pend;
  logic                    cur_ov;
  logic                    spd_ov;
  logic                    take;

  logic [SAMPLE_WIDTH-1:0]   send_cur;
  logic [SAMPLE_WIDTH-1:0]   send_spd;
  logic [DMA_DATA_WIDTH-1:0] cur_ext;
  logic [DMA_DATA_WIDTH-1:0] spd_ext;

  assign take = (state == IDLE) && cur_pend && spd_pend;

  dma_sample_latch #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_cur (
    .clock   (clock),
    .reset   (reset),
    .valid   (current_valid),
    .data    (current_data),
    .consume (take),
    .held    (cur_held),
    .pending (cur_pend),
    .overrun (cur_ov)
  );

  dma_sample_latch #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_spd (
    .clock   (clock),
    .reset   (reset),
    .valid   (speed_valid),
    .data    (speed_data),
    .consume (take),
    .held    (spd_held),
    .pending (spd_pend),
    .overrun (spd_ov)
  );

  // in-flight pair is frozen here; latches keep collecting
  always_ff @(posedge clock) begin
    if (!reset) begin
      send_cur <= '0;
      send_spd <= '0;
    end else if (take) begin
      send_cur <= cur_held;
      send_spd <= spd_held;
    end
  end

  assign cur_ext = DMA_DATA_WIDTH'($signed(send_cur));
  assign spd_ext = DMA_DATA_WIDTH'($signed(send_spd));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    dma.tvalid = 1'b0;
    dma.tdest  = '0;
    dma.tdata  = '0;
    core_start = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (take) begin
          state_n = SEND_CURRENT;
        end
      end
      SEND_CURRENT: begin
        dma.tvalid = 1'b1;
        dma.tdest  = DEST_WIDTH'(CURRENT_ADDRESS);
        dma.tdata  = cur_ext;
        if (dma.tready) begin
          state_n = SEND_SPEED;
        end
      end
      SEND_SPEED: begin
        dma.tvalid = 1'b1;
        dma.tdest  = DEST_WIDTH'(SPEED_ADDRESS);
        dma.tdata  = spd_ext;
        if (dma.tready) begin
          state_n = START;
        end
      end
      START: begin
        core_start = 1'b1;
        state_n    = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  logic [1:0]             ov_inc;
  logic [OVERRUN_WIDTH:0] ov_sum;

  assign ov_inc = {1'b0, cur_ov} + {1'b0, spd_ov};
  assign ov_sum = {1'b0, overrun_count}
                + (OVERRUN_WIDTH+1)'(ov_inc);

  always_ff @(posedge clock) begin
    if (!reset) begin
      overrun_count <= '0;
    end else if (clear_overrun) begin
      overrun_count <= '0;
    end else if (ov_sum[OVERRUN_WIDTH]) begin
      overrun_count <= '1;
    end else begin
      overrun_count <= ov_sum[OVERRUN_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_dma_input_sequencer.sv
// Directed bench for dma_input_sequencer with a beat
// scoreboard checked on every DMA handshake.
module tb_dma_input_sequencer;

  localparam int SW = 16;
  localparam int DW = 32;
  localparam int TW = 8;
  localparam int OW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          current_valid = 1'b0;
  logic          speed_valid = 1'b0;
  logic          clear_overrun = 1'b0;
  logic [SW-1:0] current_data = '0;
  logic [SW-1:0] speed_data = '0;
  logic          core_start;
  logic          busy;
  logic [OW-1:0] overrun_count;

  int checks = 0;
  int failures = 0;
  int starts = 0;
  int busy_cycles = 0;
  int ov_exp = 0;
  int s0;
  int b0;

  typedef struct packed {
    logic [TW-1:0] dest;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];

  dma_input_sequencer_if #(
    .DATA_WIDTH(DW),
    .DEST_WIDTH(TW)
  ) dma ();

  dma_input_sequencer #(
    .SAMPLE_WIDTH   (SW),
    .DMA_DATA_WIDTH (DW),
    .DEST_WIDTH     (TW),
    .CURRENT_ADDRESS(1),
    .SPEED_ADDRESS  (2),
    .OVERRUN_WIDTH  (OW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .current_valid (current_valid),
    .current_data  (current_data),
    .speed_valid   (speed_valid),
    .speed_data    (speed_data),
    .dma           (dma.master),
    .core_start    (core_start),
    .busy          (busy),
    .overrun_count (overrun_count),
    .clear_overrun (clear_overrun)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    beat_t got;
    beat_t exp;
    if (core_start) starts++;
    if (busy) busy_cycles++;
    if (reset && dma.tvalid && dma.tready) begin
      got = {dma.tdest, dma.tdata};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL beat_unexpected got=%0h", got);
      end else begin
        exp = exp_q.pop_front();
        assert (got === exp) else begin
          failures++;
          $error("FAIL beat got=%0h exp=%0h", got, exp);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [TW-1:0] d,
                      input logic [DW-1:0] v);
    exp_q.push_back({d, v});
  endtask

  initial begin
    dma.tready = 1'b0;
    tick(2);
    chk("rst_tvalid", 64'(dma.tvalid), 0);
    chk("rst_tdest", 64'(dma.tdest), 0);
    chk("rst_tdata", 64'(dma.tdata), 0);
    chk("rst_start", 64'(core_start), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ovr", 64'(overrun_count), 0);
    reset = 1'b1;
    dma.tready = 1'b1;

    // basic pair, staggered strobes
    push(8'd1, 32'h0000_0123);
    push(8'd2, 32'hFFFF_FF00);
    s0 = starts;
    b0 = busy_cycles;
    current_valid = 1'b1;
    current_data = 16'h0123;
    tick();
    current_valid = 1'b0;
    tick();
    speed_valid = 1'b1;
    speed_data = 16'hFF00;
    tick();
    speed_valid = 1'b0;
    chk("t1_idle", 64'(busy), 0);
    tick();
    chk("t1_cv", 64'(dma.tvalid), 1);
    chk("t1_cd", 64'(dma.tdest), 1);
    chk("t1_cx", 64'(dma.tdata), 64'h123);
    tick();
    chk("t1_sd", 64'(dma.tdest), 2);
    chk("t1_sx", 64'(dma.tdata), 64'hFFFF_FF00);
    tick();
    chk("t1_start", 64'(core_start), 1);
    chk("t1_nv", 64'(dma.tvalid), 0);
    chk("t1_nd", 64'(dma.tdest), 0);
    tick();
    chk("t1_busy0", 64'(busy), 0);
    chk("t1_start0", 64'(core_start), 0);
    chk("t1_starts", 64'(starts - s0), 1);
    chk("t1_busycyc", 64'(busy_cycles - b0), 3);

    // simultaneous strobes, stalled current beat
    push(8'd1, 32'hFFFF_8001);
    push(8'd2, 32'h0000_7FFF);
    s0 = starts;
    dma.tready = 1'b0;
    current_valid = 1'b1;
    current_data = 16'h8001;
    speed_valid = 1'b1;
    speed_data = 16'h7FFF;
    tick();
    current_valid = 1'b0;
    speed_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hv", 64'(dma.tvalid), 1);
      chk("t2_hd", 64'(dma.tdest), 1);
      chk("t2_hx", 64'(dma.tdata), 64'hFFFF_8001);
      tick();
    end
    dma.tready = 1'b1;
    tick();
    chk("t2_sd", 64'(dma.tdest), 2);
    chk("t2_sx", 64'(dma.tdata), 64'h7FFF);
    tick();
    chk("t2_start", 64'(core_start), 1);
    tick();
    chk("t2_starts", 64'(starts - s0), 1);

    // repeated current strobes overrun
    push(8'd1, 32'h30);
    push(8'd2, 32'h5);
    current_valid = 1'b1;
    current_data = 16'h0010;
    tick();
    current_data = 16'h0020;
    tick();
    current_data = 16'h0030;
    tick();
    current_valid = 1'b0;
    ov_exp += 2;
    speed_valid = 1'b1;
    speed_data = 16'h0005;
    tick();
    speed_valid = 1'b0;
    tick(5);
    chk("t3_ovr", 64'(overrun_count), 64'(ov_exp));
    chk("t3_busy", 64'(busy), 0);

    // new pair arrives while previous speed beat stalls
    push(8'd1, 32'h0AAA);
    push(8'd2, 32'h0BBB);
    push(8'd1, 32'h0CCC);
    push(8'd2, 32'h0DDD);
    current_valid = 1'b1;
    current_data = 16'h0AAA;
    speed_valid = 1'b1;
    speed_data = 16'h0BBB;
    tick();
    current_valid = 1'b0;
    speed_valid = 1'b0;
    tick();
    chk("t4_cd", 64'(dma.tdest), 1);
    tick();
    dma.tready = 1'b0;
    current_valid = 1'b1;
    current_data = 16'h0CCC;
    speed_valid = 1'b1;
    speed_data = 16'h0DDD;
    tick();
    current_valid = 1'b0;
    speed_valid = 1'b0;
    chk("t4_sd", 64'(dma.tdest), 2);
    chk("t4_sx", 64'(dma.tdata), 64'h0BBB);
    dma.tready = 1'b1;
    tick();
    chk("t4_start", 64'(core_start), 1);
    tick();
    chk("t4_idle", 64'(busy), 0);
    tick();
    chk("t4_2cd", 64'(dma.tdest), 1);
    chk("t4_2cx", 64'(dma.tdata), 64'h0CCC);
    tick(4);
    chk("t4_ovr", 64'(overrun_count), 64'(ov_exp));

    // reset during a stalled speed beat
    push(8'd1, 32'h0111);
    current_valid = 1'b1;
    current_data = 16'h0111;
    speed_valid = 1'b1;
    speed_data = 16'h0222;
    tick();
    current_valid = 1'b0;
    speed_valid = 1'b0;
    tick(2);
    dma.tready = 1'b0;
    current_valid = 1'b1;
    current_data = 16'h0333;
    speed_valid = 1'b1;
    speed_data = 16'h0444;
    tick();
    current_valid = 1'b0;
    speed_valid = 1'b0;
    chk("t5_inspd", 64'(dma.tdest), 2);
    s0 = starts;
    reset = 1'b0;
    tick();
    ov_exp = 0;
    chk("t5_tvalid", 64'(dma.tvalid), 0);
    chk("t5_busy", 64'(busy), 0);
    chk("t5_ovr", 64'(overrun_count), 0);
    reset = 1'b1;
    dma.tready = 1'b1;
    b0 = busy_cycles;
    tick(6);
    chk("t5_nobusy", 64'(busy_cycles - b0), 0);
    chk("t5_nostart", 64'(starts - s0), 0);
    push(8'd1, 32'h0555);
    push(8'd2, 32'h0666);
    current_valid = 1'b1;
    current_data = 16'h0555;
    speed_valid = 1'b1;
    speed_data = 16'h0666;
    tick();
    current_valid = 1'b0;
    speed_valid = 1'b0;
    tick(5);
    chk("t5_starts", 64'(starts - s0), 1);
    chk("t5_ovr2", 64'(overrun_count), 64'(ov_exp));

    // saturation and clear priority
    current_valid = 1'b1;
    current_data = 16'h0100;
    tick();
    for (int i = 1; i <= 17; i++) begin
      current_data = 16'h0100 + 16'(i);
      tick();
      ov_exp = (ov_exp == 15) ? 15 : ov_exp + 1;
    end
    current_valid = 1'b0;
    chk("t6_sat", 64'(overrun_count), 64'(ov_exp));
    clear_overrun = 1'b1;
    current_valid = 1'b1;
    current_data = 16'h0200;
    tick();
    clear_overrun = 1'b0;
    current_valid = 1'b0;
    ov_exp = 0;
    chk("t6_clr", 64'(overrun_count), 0);

    // double overrun while busy
    s0 = starts;
    dma.tready = 1'b0;
    push(8'd1, 32'h0200);
    push(8'd2, 32'hFFFF_8077);
    speed_valid = 1'b1;
    speed_data = 16'h8077;
    tick();
    speed_valid = 1'b0;
    tick();
    current_valid = 1'b1;
    current_data = 16'h0301;
    speed_valid = 1'b1;
    speed_data = 16'h0401;
    tick();
    current_data = 16'h0302;
    speed_data = 16'h0402;
    tick();
    current_valid = 1'b0;
    speed_valid = 1'b0;
    ov_exp += 2;
    chk("t6_dbl", 64'(overrun_count), 64'(ov_exp));
    chk("t6_hold", 64'(dma.tdata), 64'h0200);
    push(8'd1, 32'h0302);
    push(8'd2, 32'h0402);
    dma.tready = 1'b1;
    tick(10);
    chk("t6_starts", 64'(starts - s0), 2);
    chk("q_empty", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_input_sequencer.md
Name: dma_input_sequencer

Overview:
Upstream feeder for the current-control fCore instance. Collects one current sample and one speed sample from the acquisition chain and writes both into the core's DMA input registers over an AXI-stream-style write channel: current to address 1, speed to address 2. It then issues a one-cycle start pulse so the control program runs on a coherent sample pair. Counts sample overruns for diagnostics.

Parameters:
SAMPLE_WIDTH, 16, width of each signed input sample
DMA_DATA_WIDTH, 32, width of the DMA write data bus
DEST_WIDTH, 8, width of the DMA destination address field
CURRENT_ADDRESS, 1, DMA register written with the current sample
SPEED_ADDRESS, 2, DMA register written with the speed sample
OVERRUN_WIDTH, 16, width of the saturating overrun counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
current_valid  in  1  one-cycle strobe; current_data is valid
current_data  in  SAMPLE_WIDTH  signed current sample
speed_valid  in  1  one-cycle strobe; speed_data is valid
speed_data  in  SAMPLE_WIDTH  signed speed sample
dma_tdata  out  DMA_DATA_WIDTH  sign-extended sample being written
dma_tdest  out  DEST_WIDTH  destination DMA register address
dma_tvalid  out  1  write beat valid
dma_tready  in  1  core accepts the beat
core_start  out  1  one-cycle pulse; sample pair delivered
busy  out  1  high while a pair is in flight (state != IDLE)
overrun_count  out  OVERRUN_WIDTH  saturating count of overwritten unsent samples
clear_overrun  in  1  synchronous clear of overrun_count

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE. Both pending flags are 0. All outputs are 0: dma_tdata, dma_tdest, dma_tvalid, core_start, busy, overrun_count.
- A reset asserted mid-transfer abandons the beat: dma_tvalid drops on the next edge and no start pulse is issued.
- Inputs have no backpressure and are always accepted.
- Each channel has a holding register plus a pending flag.
  - A valid strobe loads the holding register and sets the pending flag.
  - If the flag was already set and the flag is not being consumed in that cycle: the new sample overwrites the old one, and overrun_count increments by 1 per channel. Both channels overrunning in the same cycle adds 2.
- overrun_count saturates at all-ones. clear_overrun has priority over a same-cycle increment; the result is 0.
- FSM states: IDLE, SEND_CURRENT, SEND_SPEED, START.
  - IDLE: when both pending flags are 1, snapshot both holding registers into send registers, clear both flags, and go to SEND_CURRENT.
  - A strobe arriving in the snapshot cycle sets its flag again as a fresh sample. This is not an overrun.
  - SEND_CURRENT: dma_tvalid=1, dma_tdest=CURRENT_ADDRESS, dma_tdata=sign-extended current. Hold all three stable until dma_tvalid&&dma_tready, then go to SEND_SPEED.
  - SEND_SPEED: same, with SPEED_ADDRESS and the speed sample. On handshake go to START.
  - START: core_start=1 for exactly one cycle and dma_tvalid=0, then go to IDLE.
- Samples arriving while busy only update the pending registers. The pair already in flight is never modified.
- Latency: both flags set at edge N gives the current beat valid from N+1. With dma_tready tied high: speed beat at N+2, core_start at N+3, IDLE at N+4. A new pair is accepted at N+4 at the earliest.
- Sign extension: replicate bit SAMPLE_WIDTH-1 up to DMA_DATA_WIDTH.
- dma_tdest and dma_tdata return to 0 when dma_tvalid=0.
- Elaboration check: SAMPLE_WIDTH <= DMA_DATA_WIDTH, and both addresses fit in DEST_WIDTH.

Decomposition:
- Shared package (dma_sequencer_pkg) holds:
  - the state enum {IDLE, SEND_CURRENT, SEND_SPEED, START};
  - default addresses CURRENT_DMA_ADDRESS=1, SPEED_DMA_ADDRESS=2, DUTY_DMA_ADDRESS=15, so the downstream duty reader uses the same table.
- One sub-module, dma_sample_latch, instanced per channel. It contains the holding register, pending flag, consume input and overrun pulse output. The top module owns the FSM and the saturating counter.

Test Plan:
- current=0x0123, then speed=0xFF00 two cycles later, dma_tready=1 -> beats (dest 1, 0x00000123) and (dest 2, 0xFFFFFF00) on consecutive cycles, one core_start pulse, busy high exactly 3 cycles.
- Both valid in the same cycle; dma_tready low for 5 cycles during SEND_CURRENT -> tvalid/tdest/tdata held stable for all 5 cycles; speed beat only after the handshake; single core_start.
- current strobed 3 times (0x10, 0x20, 0x30) before any speed, then speed=0x5 -> only 0x30 is sent; overrun_count=2.
- New current/speed pair strobed during SEND_SPEED of the previous pair -> in-flight speed data unchanged; second pair is sent starting at the cycle after returning to IDLE; overrun_count unchanged.
- Reset driven low for one cycle while in SEND_SPEED with dma_tready=0 -> dma_tvalid=0 and core_start never pulses; pending flags cleared; next pair is handled normally.
- overrun_count preloaded to saturation via repeated overruns (OVERRUN_WIDTH=4 override) -> holds at 15; clear_overrun asserted together with a new overrun -> count reads 0.
